// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and per-register pending-write (busy) bits.
// Register 0 reads as zero; on same-cycle write collisions the highest-index write port wins.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 4,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WR_PORTS-1:0]          we,
    input  logic [WR_PORTS*AW-1:0]       waddr,
    input  logic [WR_PORTS*DATA_W-1:0]   wdata,
    input  logic [WR_PORTS-1:0]          alloc_en,
    input  logic [WR_PORTS*AW-1:0]       alloc_addr,
    input  logic                         flush,
    input  logic [RD_PORTS-1:0]          re,
    input  logic [RD_PORTS*AW-1:0]       raddr,
    output logic [RD_PORTS*DATA_W-1:0]   rdata,
    output logic [RD_PORTS-1:0]          rready,
    output logic [REG_NUM-1:0]           busy_vec,
    output logic [REG_NUM*DATA_W-1:0]    debug_reg
);

    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    // Next-state: commit writes (later ports override earlier), clear busy on commit, then allocate or flush.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (we[i] && (waddr[i*AW +: AW] == AW'(r))) begin
                    regs_d[r] = wdata[i*DATA_W +: DATA_W];
                    busy_d[r] = 1'b0;
                end else begin
                    regs_d[r] = regs_d[r];
                    busy_d[r] = busy_d[r];
                end
            end
            // Allocation belongs to a younger instruction, so it overrides a same-cycle clear.
            if (flush) begin
                busy_d[r] = 1'b0;
            end else begin
                for (int i = 0; i < WR_PORTS; i++) begin
                    busy_d[r] = busy_d[r] | (alloc_en[i] && (alloc_addr[i*AW +: AW] == AW'(r)));
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: zero register, enable, then same-cycle write bypass, then stored value.
    always_comb begin
        logic              byp_hit;
        logic [DATA_W-1:0] byp_data;
        logic [AW-1:0]     ra;
        rdata  = '0;
        rready = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
            ra       = raddr[j*AW +: AW];
            byp_hit  = 1'b0;
            byp_data = '0;
            for (int i = 0; i < WR_PORTS; i++) begin
                if (we[i] && (waddr[i*AW +: AW] == ra)) begin
                    byp_hit  = 1'b1;
                    byp_data = wdata[i*DATA_W +: DATA_W];
                end else begin
                    byp_hit  = byp_hit;
                    byp_data = byp_data;
                end
            end
            if (!rst) begin
                rready[j] = 1'b0;
            end else if (ra == '0) begin
                rready[j] = 1'b1;
            end else if (!re[j]) begin
                rready[j] = 1'b0;
            end else if (byp_hit) begin
                rdata[j*DATA_W +: DATA_W] = byp_data;
                rready[j]                 = 1'b1;
            end else begin
                rdata[j*DATA_W +: DATA_W] = regs_q[ra];
                rready[j]                 = !busy_q[ra];
            end
        end
    end

    assign busy_vec = rst ? busy_q : '0;

    for (genvar r = 0; r < REG_NUM; r++) begin : g_dbg
        assign debug_reg[r*DATA_W +: DATA_W] = rst ? regs_q[r] : '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 2W/4R/32x32 and a 4W/8R/64x64 instance share one stimulus stream
// and are checked against an array-based reference model of the register file and its busy bits.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        we_s [4];
    logic [5:0]  wa_s [4];
    logic [63:0] wd_s [4];
    logic        al_s [4];
    logic [5:0]  aa_s [4];
    logic        re_s [8];
    logic [5:0]  ra_s [8];

    logic [1:0]    a_we, a_al;
    logic [9:0]    a_wa, a_aa;
    logic [63:0]   a_wd;
    logic [3:0]    a_re, a_rr;
    logic [19:0]   a_ra;
    logic [127:0]  a_rd;
    logic [31:0]   a_busy;
    logic [1023:0] a_dbg;

    logic [3:0]    b_we, b_al;
    logic [23:0]   b_wa, b_aa;
    logic [255:0]  b_wd;
    logic [7:0]    b_re, b_rr;
    logic [47:0]   b_ra;
    logic [511:0]  b_rd;
    logic [63:0]   b_busy;
    logic [4095:0] b_dbg;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_we[i]        = we_s[i];
            a_wa[i*5 +: 5] = wa_s[i][4:0];
            a_wd[i*32 +: 32] = wd_s[i][31:0];
            a_al[i]        = al_s[i];
            a_aa[i*5 +: 5] = aa_s[i][4:0];
        end
        for (int j = 0; j < 4; j++) begin
            a_re[j]        = re_s[j];
            a_ra[j*5 +: 5] = ra_s[j][4:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b_we[i]          = we_s[i];
            b_wa[i*6 +: 6]   = wa_s[i];
            b_wd[i*64 +: 64] = wd_s[i];
            b_al[i]          = al_s[i];
            b_aa[i*6 +: 6]   = aa_s[i];
        end
        for (int j = 0; j < 8; j++) begin
            b_re[j]        = re_s[j];
            b_ra[j*6 +: 6] = ra_s[j];
        end
    end

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst), .we(a_we), .waddr(a_wa), .wdata(a_wd),
        .alloc_en(a_al), .alloc_addr(a_aa), .flush(flush), .re(a_re), .raddr(a_ra),
        .rdata(a_rd), .rready(a_rr), .busy_vec(a_busy), .debug_reg(a_dbg)
    );

    regfile_mp #(.DATA_W(64), .REG_NUM(64), .WR_PORTS(4), .RD_PORTS(8)) u_dut_b (
        .clk(clk), .rst(rst), .we(b_we), .waddr(b_wa), .wdata(b_wd),
        .alloc_en(b_al), .alloc_addr(b_aa), .flush(flush), .re(b_re), .raddr(b_ra),
        .rdata(b_rd), .rready(b_rr), .busy_vec(b_busy), .debug_reg(b_dbg)
    );

    // Reference model state, one slice per configuration.
    logic [63:0] m_regs [2][64];
    bit          m_busy [2][64];

    typedef struct {
        int          cfg;
        int          kind;   // 0 read port, 1 busy_vec, 2 debug register
        int          idx;
        logic [63:0] exp_d;
        logic        exp_r;
    } chk_t;
    chk_t sbq[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int nw(int c);   return (c == 0) ? 2 : 4;   endfunction
    function automatic int nr(int c);   return (c == 0) ? 4 : 8;   endfunction
    function automatic int nreg(int c); return (c == 0) ? 32 : 64; endfunction
    function automatic logic [63:0] dmask(int c);
        return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic push_checks();
        chk_t e;
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < nr(c); j++) begin
                int a;
                a = int'(ra_s[j]) % nreg(c);
                e.cfg = c; e.kind = 0; e.idx = j; e.exp_d = 64'd0; e.exp_r = 1'b0;
                if (!rst) begin
                    e.exp_r = 1'b0;
                end else if (a == 0) begin
                    e.exp_r = 1'b1;
                end else if (re_s[j]) begin
                    int winner;
                    winner = -1;
                    for (int p = 0; p < nw(c); p++)
                        if (we_s[p] && (int'(wa_s[p]) % nreg(c)) == a) winner = p;
                    if (winner >= 0) begin
                        e.exp_d = wd_s[winner] & dmask(c);
                        e.exp_r = 1'b1;
                    end else begin
                        e.exp_d = m_regs[c][a];
                        e.exp_r = !m_busy[c][a];
                    end
                end
                sbq.push_back(e);
            end
            e.cfg = c; e.kind = 1; e.idx = 0; e.exp_d = 64'd0; e.exp_r = 1'b0;
            for (int r = 0; r < nreg(c); r++) e.exp_d[r] = rst && m_busy[c][r];
            sbq.push_back(e);
            for (int r = 0; r < nreg(c); r++) begin
                e.cfg = c; e.kind = 2; e.idx = r; e.exp_r = 1'b0;
                e.exp_d = rst ? m_regs[c][r] : 64'd0;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic update_model();
        for (int c = 0; c < 2; c++) begin
            if (!rst) begin
                for (int r = 0; r < 64; r++) begin
                    m_regs[c][r] = 64'd0;
                    m_busy[c][r] = 1'b0;
                end
            end else begin
                for (int p = 0; p < nw(c); p++) begin
                    int a;
                    a = int'(wa_s[p]) % nreg(c);
                    if (we_s[p] && a != 0) begin
                        m_regs[c][a] = wd_s[p] & dmask(c);
                        m_busy[c][a] = 1'b0;
                    end
                end
                for (int p = 0; p < nw(c); p++) begin
                    int a;
                    a = int'(aa_s[p]) % nreg(c);
                    if (flush) m_busy[c][a] = 1'b0;
                    else if (al_s[p] && a != 0) m_busy[c][a] = 1'b1;
                end
                if (flush)
                    for (int r = 0; r < 64; r++) m_busy[c][r] = 1'b0;
            end
        end
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we_s[i] = 1'b0; wa_s[i] = 6'd0; wd_s[i] = 64'd0; al_s[i] = 1'b0; aa_s[i] = 6'd0;
        end
        for (int j = 0; j < 8; j++) begin
            re_s[j] = 1'b0; ra_s[j] = 6'd0;
        end
    endtask

    task automatic step();
        push_checks();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int j, input logic [5:0] a);
        re_s[j] = 1'b1; ra_s[j] = a;
    endtask

    task automatic wr(input int p, input logic [5:0] a, input logic [63:0] d);
        we_s[p] = 1'b1; wa_s[p] = a; wd_s[p] = d;
    endtask

    task automatic al(input int p, input logic [5:0] a);
        al_s[p] = 1'b1; aa_s[p] = a;
    endtask

    function automatic logic [5:0] rand_addr();
        logic [5:0] a;
        if ($urandom_range(0, 1) == 0) a = 6'($urandom_range(0, 7));
        else                           a = 6'($urandom_range(0, 63));
        return a;
    endfunction

    // Monitor: every cycle, compare everything the driver queued against the DUT outputs.
    initial begin
        chk_t        e;
        logic [63:0] act_d;
        logic        act_r;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                act_d = 64'd0;
                act_r = 1'b0;
                if (e.cfg == 0) begin
                    case (e.kind)
                        0: begin act_d = {32'd0, a_rd[e.idx*32 +: 32]}; act_r = a_rr[e.idx]; end
                        1: act_d = {32'd0, a_busy};
                        default: act_d = {32'd0, a_dbg[e.idx*32 +: 32]};
                    endcase
                end else begin
                    case (e.kind)
                        0: begin act_d = b_rd[e.idx*64 +: 64]; act_r = b_rr[e.idx]; end
                        1: act_d = b_busy;
                        default: act_d = b_dbg[e.idx*64 +: 64];
                    endcase
                end
                n_chk++;
                if (act_d === e.exp_d && act_r === e.exp_r) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cfg%0d idx%0d t=%0t: got %h/%b expected %h/%b",
                             (e.kind == 0) ? "rdata/rready" : (e.kind == 1) ? "busy_vec" : "debug_reg",
                             e.cfg, e.idx, $time, act_d, act_r, e.exp_d, e.exp_r);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 64; r++) begin
                m_regs[c][r] = 64'd0;
                m_busy[c][r] = 1'b0;
            end
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        idle(); rst = 1'b0; step();
        idle(); rst = 1'b0; rd(0, 6'd5); step();
        idle(); rd(0, 6'd5); step();

        idle(); wr(0, 6'd3, 64'h1111_1111); wr(1, 6'd3, 64'h2222_2222); rd(0, 6'd3); step();
        idle(); rd(1, 6'd3); step();
        idle(); wr(0, 6'd0, 64'hFFFF_FFFF); rd(2, 6'd0); step();

        idle(); al(0, 6'd7); step();
        idle(); rd(0, 6'd7); step();
        idle(); rd(0, 6'd7); step();
        idle(); wr(1, 6'd7, 64'hABCD_0001); rd(0, 6'd7); step();
        idle(); rd(0, 6'd7); step();

        idle(); wr(0, 6'd9, 64'h0000_0099); al(1, 6'd9); step();
        idle(); rd(3, 6'd9); step();

        idle(); al(0, 6'd4); al(1, 6'd6); step();
        idle(); flush = 1'b1; al(0, 6'd8); wr(1, 6'd10, 64'h5); step();
        idle(); rd(0, 6'd10); rd(1, 6'd8); step();

        idle(); al(0, 6'd12); step();
        idle(); rst = 1'b0; wr(0, 6'd12, 64'h1234); al(1, 6'd12); step();
        idle(); rd(0, 6'd12); step();

        idle();
        for (int p = 0; p < 4; p++) wr(p, 6'd20, 64'hC0DE_0000_0000_0010 + 64'(p));
        rd(0, 6'd20); rd(7, 6'd20); step();
        idle(); wr(3, 6'd21, 64'hFFFF_0000_FFFF_0003); wr(2, 6'd21, 64'h2); rd(5, 6'd21); step();
        idle(); rd(0, 6'd20); rd(1, 6'd21); rd(6, 6'd20); step();

        for (int n = 0; n < 400; n++) begin
            idle();
            rst   = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 4; p++) begin
                we_s[p] = ($urandom_range(0, 1) == 0);
                wa_s[p] = rand_addr();
                wd_s[p] = {$urandom(), $urandom()};
                al_s[p] = ($urandom_range(0, 3) == 0);
                aa_s[p] = rand_addr();
            end
            for (int j = 0; j < 8; j++) begin
                re_s[j] = ($urandom_range(0, 3) != 0);
                ra_s[j] = rand_addr();
            end
            step();
        end

        idle();
        for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
